line_raster_engine: RTL and testbench

//  Parametrised all-octant Bresenham line rasteriser; successor to the single-octant drawer.

---
 rtl/gfx_pkg.sv | 14 +
 rtl/bresenham_step.sv | 46 ++++
 rtl/line_raster_engine.sv | 162 ++++++++++++++++
 tb/tb_line_raster_engine.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and defaults for the line rasteriser.
// Coordinate/colour widths and the engine state encoding.
package gfx_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_COLOR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step for any octant.
// Both axis decisions use the same pre-step error term.
module bresenham_step
    import gfx_pkg::*;
#(
    parameter int W = DEF_COORD_W
) (
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    input  logic signed [W+1:0] err,
    input  logic signed [W+1:0] dx,
    input  logic signed [W+1:0] dy,
    input  logic                sx_neg,
    input  logic                sy_neg,
    output logic [W-1:0]        x_nxt,
    output logic [W-1:0]        y_nxt,
    output logic signed [W+1:0] err_nxt
);

    logic signed [W+2:0] e2;
    logic signed [W+2:0] dx_w;
    logic signed [W+2:0] dy_w;
    logic                step_x;
    logic                step_y;

    always_comb begin
        e2     = (W+3)'(err) <<< 1;
        dx_w   = (W+3)'(dx);
        dy_w   = (W+3)'(dy);
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
    end

    always_comb begin
        err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        x_nxt   = x;
        y_nxt   = y;
        if (step_x) begin
            x_nxt = sx_neg ? x - 1'b1 : x + 1'b1;
        end
        if (step_y) begin
            y_nxt = sy_neg ? y - 1'b1 : y + 1'b1;
        end
    end

endmodule

// File: rtl/line_raster_engine.sv
// All-octant Bresenham line rasteriser with clipping and a
// backpressured one-pixel-per-cycle output stream.
module line_raster_engine
    import gfx_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter bit CLIP_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [COORD_W-1:0] x0_in,
    input  logic [COORD_W-1:0] y0_in,
    input  logic [COORD_W-1:0] x1_in,
    input  logic [COORD_W-1:0] y1_in,
    input  logic [COLOR_W-1:0] color,
    input  logic               in_rts,
    output logic               in_rtr,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_last,
    output logic               out_rts,
    input  logic               out_rtr,
    output logic               busy,
    output logic               line_done
);

    localparam int EW = COORD_W + 2;

    state_t state;
    state_t state_nxt;

    logic [COORD_W-1:0] x0_q;
    logic [COORD_W-1:0] y0_q;
    logic [COORD_W-1:0] x1_q;
    logic [COORD_W-1:0] y1_q;
    logic [COLOR_W-1:0] color_q;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic signed [EW-1:0] dx_q;
    logic signed [EW-1:0] dy_q;
    logic signed [EW-1:0] err_q;
    logic sx_neg;
    logic sy_neg;

    logic [COORD_W-1:0] dx_abs;
    logic [COORD_W-1:0] dy_abs;
    logic signed [EW-1:0] dx_init;
    logic signed [EW-1:0] dy_init;

    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic signed [EW-1:0] nerr;

    logic drawing;
    logic visible;
    logic at_end;
    logic step;

    always_comb begin
        dx_abs  = (x0_q < x1_q) ? x1_q - x0_q : x0_q - x1_q;
        dy_abs  = (y0_q < y1_q) ? y1_q - y0_q : y0_q - y1_q;
        dx_init = $signed({2'b00, dx_abs});
        dy_init = -$signed({2'b00, dy_abs});
    end

    // Clipped pixels never reach the stream, so they step without waiting.
    always_comb begin
        drawing = (state == DRAW);
        visible = !CLIP_EN
               || ((int'(cur_x) < SCREEN_W) && (int'(cur_y) < SCREEN_H));
        at_end  = (cur_x == x1_q) && (cur_y == y1_q);
        step    = drawing && (!visible || out_rtr);
    end

    bresenham_step #(
        .W(COORD_W)
    ) u_step (
        .x      (cur_x),
        .y      (cur_y),
        .err    (err_q),
        .dx     (dx_q),
        .dy     (dy_q),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .x_nxt  (nx),
        .y_nxt  (ny),
        .err_nxt(nerr)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_rts) state_nxt = SETUP;
            SETUP:   state_nxt = DRAW;
            DRAW:    if (step && at_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rtr    = (state == IDLE);
        busy      = (state != IDLE);
        out_rts   = drawing && visible;
        out_last  = drawing && at_end;
        line_done = step && at_end;
        out_x     = cur_x;
        out_y     = cur_y;
        out_color = color_q;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            if (state == IDLE && in_rts) begin
                x0_q    <= x0_in;
                y0_q    <= y0_in;
                x1_q    <= x1_in;
                y1_q    <= y1_in;
                color_q <= color;
            end
            if (state == SETUP) begin
                dx_q   <= dx_init;
                dy_q   <= dy_init;
                err_q  <= dx_init + dy_init;
                sx_neg <= !(x0_q < x1_q);
                sy_neg <= !(y0_q < y1_q);
                cur_x  <= x0_q;
                cur_y  <= y0_q;
            end
            if (step && !at_end) begin
                cur_x <= nx;
                cur_y <= ny;
                err_q <= nerr;
            end
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: table of lines plus
// stall and mid-line reset sequences.
module tb_line_raster_engine;

    logic        clk = 1'b0;
    logic        rst_;
    logic [9:0]  x0_in, y0_in, x1_in, y1_in;
    logic [11:0] color;
    logic        in_rts;
    logic        in_rtr;
    logic [9:0]  out_x, out_y;
    logic [11:0] out_color;
    logic        out_last, out_rts, out_rtr, busy, line_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_raster_engine dut (
        .clk      (clk),
        .rst_     (rst_),
        .x0_in    (x0_in),
        .y0_in    (y0_in),
        .x1_in    (x1_in),
        .y1_in    (y1_in),
        .color    (color),
        .in_rts   (in_rts),
        .in_rtr   (in_rtr),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_color(out_color),
        .out_last (out_last),
        .out_rts  (out_rts),
        .out_rtr  (out_rtr),
        .busy     (busy),
        .line_done(line_done)
    );

    typedef struct {
        logic [9:0]  x0, y0, x1, y1;
        logic [11:0] col;
        int          n;
        int          base;
        int          last;
    } vec_t;

    vec_t        tbl [4];
    logic [19:0] exp_px [15];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input int stall_at,
                           input int stall_len, input int rst_at);
        vec_t v;
        int beats, cyc, stalled, dones, first;
        bit done;
        v = tbl[vi];
        beats = 0; cyc = 0; stalled = 0; dones = 0; first = -1; done = 0;
        @(negedge clk);
        chk("idle_in_rtr", in_rtr, 1);
        x0_in = v.x0; y0_in = v.y0; x1_in = v.x1; y1_in = v.y1;
        color = v.col; in_rts = 1'b1;
        @(posedge clk);
        #1 in_rts = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (beats == rst_at) begin
                rst_ = 1'b1;
                break;
            end
            out_rtr = !(beats == stall_at && stalled < stall_len);
            #1;
            if (cyc == 1) begin
                chk("busy_setup", busy, 1);
                chk("in_rtr_busy", in_rtr, 0);
                chk("rts_setup", out_rts, 0);
            end
            if (out_rts) begin
                if (first < 0) first = cyc;
                if (beats < v.n) begin
                    chk("pix_x", out_x, exp_px[v.base+beats][19:10]);
                    chk("pix_y", out_y, exp_px[v.base+beats][9:0]);
                end
                chk("pix_last", out_last, (beats == v.last) ? 1 : 0);
                chk("pix_color", out_color, v.col);
                if (out_rtr) beats++;
                else stalled++;
            end
            if (line_done) begin
                dones++;
                done = 1;
            end
        end
        out_rtr = 1'b1;
        if (rst_at >= 0) return;
        chk("line_timeout", done, 1);
        chk("beat_count", beats, v.n);
        chk("done_count", dones, 1);
        chk("first_latency", first, 2);
        chk("stall_cycles", stalled, stall_len);
        @(negedge clk);
        #1;
        chk("idle_after_rtr", in_rtr, 1);
        chk("idle_after_busy", busy, 0);
        chk("idle_after_done", line_done, 0);
    endtask

    initial begin
        int spurious;
        tbl[0] = '{10'd0,   10'd0, 10'd5,   10'd2, 12'hF00, 6, 0,  5};
        tbl[1] = '{10'd2,   10'd5, 10'd2,   10'd1, 12'h0A5, 5, 6,  4};
        tbl[2] = '{10'd4,   10'd4, 10'd4,   10'd4, 12'h123, 1, 11, 0};
        tbl[3] = '{10'd637, 10'd0, 10'd642, 10'd0, 12'hFFF, 3, 12, -1};
        exp_px = '{
            {10'd0, 10'd0}, {10'd1, 10'd0}, {10'd2, 10'd1},
            {10'd3, 10'd1}, {10'd4, 10'd2}, {10'd5, 10'd2},
            {10'd2, 10'd5}, {10'd2, 10'd4}, {10'd2, 10'd3},
            {10'd2, 10'd2}, {10'd2, 10'd1},
            {10'd4, 10'd4},
            {10'd637, 10'd0}, {10'd638, 10'd0}, {10'd639, 10'd0}
        };

        rst_ = 1'b1; in_rts = 1'b0; out_rtr = 1'b1;
        x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0; color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rtr", in_rtr, 1);
        chk("rst_out_rts", out_rts, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_color", out_color, 0);
        rst_ = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(i, -1, 0, -1);
        end

        run_vec(0, 2, 3, -1);

        run_vec(0, -1, 0, 2);
        @(negedge clk);
        #1;
        chk("rst_mid_rts", out_rts, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rtr", in_rtr, 1);
        chk("rst_mid_done", line_done, 0);
        rst_ = 1'b0;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_rts || line_done || busy) spurious++;
        end
        chk("rst_mid_quiet", spurious, 0);

        run_vec(0, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
